daq_fifo_rst_seq_tmr: RTL and testbench

- Parametrised, triple-modular-redundant power-up/re-arm reset sequencer for a bank of DAQ FIFOs.
- Runs the sequence Idle → Clear → Reset_FIFOs → Pause → Run and drives per-channel FIFO resets.
- Gates the reset with a channel-enable mask and waits for every enabled FIFO to report reset-busy low before asserting DONE.
- Supports software re-arm from Run and flags TMR replica disagreement. Sits between the clock/reset manager and the per-channel DAQ FIFOs.

---
 rtl/daq_fifo_rst_pkg.sv | 23 ++
 rtl/tmr_vote.sv | 24 ++
 rtl/daq_fifo_rst_seq_tmr.sv | 193 +++++++++++++++++++
 tb/tb_daq_fifo_rst_seq_tmr.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/daq_fifo_rst_pkg.sv
// Shared types for the TMR FIFO reset sequencer: state encoding, debug view
// and the scalar 2-of-3 voter used by every replicated register group.
package daq_fifo_rst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RSTF  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_RUN   = 3'd4
    } state_e;

    // mismatch bits: [0] state, [1] cnt, [2] en_lat, [3] output group
    typedef struct packed {
        state_e     state;
        logic [3:0] mismatch;
    } dbg_t;

    function automatic logic vote3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter; mismatch_o flags any replica that disagrees
// with the voted result.
module tmr_vote
    import daq_fifo_rst_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] y_o,
    output logic         mismatch_o
);

    always_comb begin
        y_o = '0;
        for (int i = 0; i < W; i++) begin
            y_o[i] = vote3(a_i[i], b_i[i], c_i[i]);
        end
    end

    assign mismatch_o = (a_i != y_o) || (b_i != y_o) || (c_i != y_o);

endmodule

// File: rtl/daq_fifo_rst_seq_tmr.sv
// Triple-modular-redundant reset sequencer for a bank of DAQ FIFOs:
// Idle -> Clear -> Reset_FIFOs -> Pause -> Run, with software re-arm from Run.
module daq_fifo_rst_seq_tmr
    import daq_fifo_rst_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int CNT_W     = 8,
    parameter int CLR_CYC   = 5,
    parameter int RST_CYC   = 10,
    parameter int PAUSE_CYC = 15,
    parameter int TMO_CYC   = 255
) (
    input  logic           CLK,
    input  logic           RST_B,
    input  logic [NCH-1:0] CH_EN,
    input  logic           REARM,
    input  logic [NCH-1:0] RST_BUSY,
    output logic [NCH-1:0] FIFO_RST,
    output logic           DONE,
    output logic           BUSY,
    output logic           TIMEOUT,
    output logic           TMR_ERR,
    output dbg_t           DBG
);

    localparam logic [CNT_W-1:0] CLR_C   = CNT_W'(CLR_CYC);
    localparam logic [CNT_W-1:0] RST_C   = CNT_W'(RST_CYC);
    localparam logic [CNT_W-1:0] PAUSE_C = CNT_W'(PAUSE_CYC);
    localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(TMO_CYC);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam int               OW      = NCH + 3;

    state_e           st_rep  [3];
    logic [CNT_W-1:0] cnt_rep [3];
    logic [NCH-1:0]   en_rep  [3];
    logic [OW-1:0]    out_rep [3];

    logic [2:0]       st_vb;
    state_e           st_v;
    logic [CNT_W-1:0] cnt_v;
    logic [NCH-1:0]   en_v;
    logic [OW-1:0]    out_v;
    logic             tmo_v;
    logic [3:0]       mm;
    logic             tmr_err_q;

    // Each replica owns its next-state logic and reloads from voted values,
    // so a single upset is scrubbed on the following edge.
    for (genvar r = 0; r < 3; r++) begin : g_rep
        state_e           st_q, st_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [NCH-1:0]   en_q, en_d;
        logic [NCH-1:0]   frst_q, frst_d;
        logic             done_q, done_d;
        logic             busy_q, busy_d;
        logic             tmo_q, tmo_d;

        always_comb begin
            st_d   = st_v;
            cnt_d  = cnt_v;
            en_d   = en_v;
            tmo_d  = tmo_v;
            frst_d = '0;
            done_d = 1'b0;
            busy_d = 1'b1;
            case (st_v)
                ST_IDLE: begin
                    st_d  = ST_CLEAR;
                    cnt_d = ONE;
                    en_d  = CH_EN;
                end
                ST_CLEAR: begin
                    if (cnt_v == CLR_C) begin
                        st_d   = ST_RSTF;
                        cnt_d  = ONE;
                        frst_d = en_v;
                    end else begin
                        cnt_d = cnt_v + ONE;
                    end
                end
                ST_RSTF: begin
                    if (cnt_v == RST_C) begin
                        st_d  = ST_PAUSE;
                        cnt_d = ONE;
                    end else begin
                        cnt_d  = cnt_v + ONE;
                        frst_d = en_v;
                    end
                end
                ST_PAUSE: begin
                    if (cnt_v >= PAUSE_C && (RST_BUSY & en_v) == '0) begin
                        st_d   = ST_RUN;
                        cnt_d  = '0;
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else if (cnt_v == TMO_C) begin
                        st_d   = ST_RUN;
                        cnt_d  = '0;
                        done_d = 1'b1;
                        busy_d = 1'b0;
                        tmo_d  = 1'b1;
                    end else if (cnt_v != '1) begin
                        cnt_d = cnt_v + ONE;
                    end
                end
                ST_RUN: begin
                    if (REARM) begin
                        st_d  = ST_CLEAR;
                        cnt_d = ONE;
                        en_d  = CH_EN;
                        tmo_d = 1'b0;
                    end else begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end
                end
                default: begin
                    // Illegal voted encoding: restart with every FIFO held in reset
                    st_d   = ST_IDLE;
                    cnt_d  = '0;
                    frst_d = '1;
                end
            endcase
        end

        always_ff @(posedge CLK or negedge RST_B) begin
            if (!RST_B) begin
                st_q   <= ST_IDLE;
                cnt_q  <= '0;
                en_q   <= '1;
                frst_q <= '1;
                done_q <= 1'b0;
                busy_q <= 1'b1;
                tmo_q  <= 1'b0;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                en_q   <= en_d;
                frst_q <= frst_d;
                done_q <= done_d;
                busy_q <= busy_d;
                tmo_q  <= tmo_d;
            end
        end

        assign st_rep[r]  = st_q;
        assign cnt_rep[r] = cnt_q;
        assign en_rep[r]  = en_q;
        assign out_rep[r] = {frst_q, done_q, busy_q, tmo_q};
    end

    tmr_vote #(.W(3)) u_vote_st (
        .a_i(st_rep[0]), .b_i(st_rep[1]), .c_i(st_rep[2]),
        .y_o(st_vb), .mismatch_o(mm[0])
    );

    tmr_vote #(.W(CNT_W)) u_vote_cnt (
        .a_i(cnt_rep[0]), .b_i(cnt_rep[1]), .c_i(cnt_rep[2]),
        .y_o(cnt_v), .mismatch_o(mm[1])
    );

    tmr_vote #(.W(NCH)) u_vote_en (
        .a_i(en_rep[0]), .b_i(en_rep[1]), .c_i(en_rep[2]),
        .y_o(en_v), .mismatch_o(mm[2])
    );

    tmr_vote #(.W(OW)) u_vote_out (
        .a_i(out_rep[0]), .b_i(out_rep[1]), .c_i(out_rep[2]),
        .y_o(out_v), .mismatch_o(mm[3])
    );

    assign st_v = state_e'(st_vb);
    assign tmo_v = out_v[0];

    // Error flag covers the control registers only; it is not sticky.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            tmr_err_q <= 1'b0;
        end else begin
            tmr_err_q <= mm[0] | mm[1] | mm[2];
        end
    end

    assign FIFO_RST     = out_v[OW-1:3];
    assign DONE         = out_v[2];
    assign BUSY         = out_v[1];
    assign TIMEOUT      = out_v[0];
    assign TMR_ERR      = tmr_err_q;
    assign DBG.state    = st_v;
    assign DBG.mismatch = mm;

endmodule

// File: tb/tb_daq_fifo_rst_seq_tmr.sv
// Randomised bench for the TMR FIFO reset sequencer, compared every cycle
// against a phase/elapsed-time model plus literal timing expectations.
module tb_daq_fifo_rst_seq_tmr;
    import daq_fifo_rst_pkg::*;

    localparam int NCH = 4;
    localparam int CLR_CYC = 5;
    localparam int RST_CYC = 10;
    localparam int PAUSE_CYC = 15;
    localparam int TMO_CYC = 255;

    localparam int P_IDLE = 0, P_CLEAR = 1, P_RSTF = 2, P_PAUSE = 3, P_RUN = 4;

    // clock / reset
    logic           CLK = 1'b0;
    logic           RST_B = 1'b1;
    logic [NCH-1:0] CH_EN = '1;
    logic           REARM = 1'b0;
    logic [NCH-1:0] RST_BUSY = '0;
    logic [NCH-1:0] FIFO_RST;
    logic           DONE, BUSY, TIMEOUT, TMR_ERR;
    dbg_t           DBG;

    always #5 CLK = ~CLK;

    daq_fifo_rst_seq_tmr #(
        .NCH(NCH), .CNT_W(8), .CLR_CYC(CLR_CYC), .RST_CYC(RST_CYC),
        .PAUSE_CYC(PAUSE_CYC), .TMO_CYC(TMO_CYC)
    ) dut (
        .CLK(CLK), .RST_B(RST_B), .CH_EN(CH_EN), .REARM(REARM),
        .RST_BUSY(RST_BUSY), .FIFO_RST(FIFO_RST), .DONE(DONE), .BUSY(BUSY),
        .TIMEOUT(TIMEOUT), .TMR_ERR(TMR_ERR), .DBG(DBG)
    );

    int n_total = 0;
    int n_bad = 0;
    int busy_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: current phase, the global edge count at which it was entered.
    int             m_ph = P_IDLE;
    int             m_cyc = 0;
    int             m_t0 = 0;
    int             m_err_cyc = -1;
    logic [NCH-1:0] m_en = '1;
    logic           m_tmo = 1'b0;

    always @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            m_ph = P_IDLE; m_cyc = 0; m_t0 = 0; m_en = '1; m_tmo = 1'b0; m_err_cyc = -1;
        end else begin
            int d;
            m_cyc++;
            d = m_cyc - m_t0;
            case (m_ph)
                P_IDLE:  begin m_ph = P_CLEAR; m_t0 = m_cyc; m_en = CH_EN; end
                P_CLEAR: if (d == CLR_CYC) begin m_ph = P_RSTF; m_t0 = m_cyc; end
                P_RSTF:  if (d == RST_CYC) begin m_ph = P_PAUSE; m_t0 = m_cyc; end
                P_PAUSE: begin
                    if (d >= PAUSE_CYC && (RST_BUSY & m_en) == '0) begin
                        m_ph = P_RUN; m_t0 = m_cyc;
                    end else if (d >= TMO_CYC) begin
                        m_ph = P_RUN; m_t0 = m_cyc; m_tmo = 1'b1;
                    end
                end
                default: if (REARM) begin
                    m_ph = P_CLEAR; m_t0 = m_cyc; m_en = CH_EN; m_tmo = 1'b0;
                end
            endcase
        end
    end

    function automatic logic [NCH-1:0] exp_fifo();
        if (m_ph == P_IDLE) return '1;
        if (m_ph == P_RSTF) return m_en;
        return '0;
    endfunction

    // scoreboard: every cycle
    always @(negedge CLK) begin
        check("fifo_rst", 32'(FIFO_RST), 32'(exp_fifo()));
        check("done", 32'(DONE), 32'(m_ph == P_RUN));
        check("busy", 32'(BUSY), 32'(m_ph != P_RUN));
        check("timeout", 32'(TIMEOUT), 32'(m_tmo));
        check("tmr_err", 32'(TMR_ERR), 32'(m_cyc == m_err_cyc));
        check("state", 32'(DBG.state), 32'(m_ph));
    end

    // driver tasks
    task automatic tick();
        @(negedge CLK);
        REARM = 1'b0;
        case (busy_mode)
            0: RST_BUSY = '0;
            1: for (int i = 0; i < NCH; i++) RST_BUSY[i] = ($urandom_range(0, 3) == 0);
            2: RST_BUSY = (m_ph == P_PAUSE && (m_cyc - m_t0) < 40) ? 4'b0100 : 4'b0000;
            default: RST_BUSY = 4'b0100;
        endcase
    endtask

    task automatic inject();
        force dut.g_rep[1].st_q = ST_PAUSE;
        m_err_cyc = m_cyc + 1;
        #1 release dut.g_rep[1].st_q;
    endtask

    // Steps until DONE; returns edge count from sequence start and observed activity.
    task automatic run_seq(input int budget, input int inj_e, input int rearm_e,
                           output int edges, output logic [NCH-1:0] fr_or,
                           output int fr_cnt, output int err_cnt);
        edges = 0; fr_or = '0; fr_cnt = 0; err_cnt = 0;
        while (1) begin
            tick();
            edges++;
            fr_or = fr_or | FIFO_RST;
            if (FIFO_RST != '0) fr_cnt++;
            if (TMR_ERR) err_cnt++;
            if (DONE) break;
            if (edges >= budget) begin
                check("done_within_budget", 32'(DONE), 32'd1);
                break;
            end
            if (edges == inj_e) inject();
            if (edges == rearm_e) REARM = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges, fr_cnt, err_cnt;
        logic [NCH-1:0] fr_or;

        #1 RST_B = 1'b0;
        tick(); tick();
        check("rst_fifo", 32'(FIFO_RST), 32'h0f);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd1);
        check("rst_timeout", 32'(TIMEOUT), 32'd0);
        check("rst_tmr_err", 32'(TMR_ERR), 32'd0);

        // power-up, all channels, no busy
        CH_EN = 4'b1111; busy_mode = 0; RST_B = 1'b1;
        run_seq(400, -1, -1, edges, fr_or, fr_cnt, err_cnt);
        check("a_done_edge", edges, 31);
        check("a_fifo_cycles", fr_cnt, 10);
        check("a_fifo_or", 32'(fr_or), 32'h0f);

        // re-arm with partial mask, REARM pulse during Reset_FIFOs ignored
        CH_EN = 4'b0101; REARM = 1'b1;
        run_seq(400, -1, 8, edges, fr_or, fr_cnt, err_cnt);
        check("b_done_edge", edges, 31);
        check("b_fifo_or", 32'(fr_or), 32'h05);
        check("b_fifo_cycles", fr_cnt, 10);

        // busy held 40 Pause cycles
        CH_EN = 4'b0110; busy_mode = 2; REARM = 1'b1;
        run_seq(400, -1, -1, edges, fr_or, fr_cnt, err_cnt);
        check("c_done_edge", edges, 57);
        check("c_timeout", 32'(TIMEOUT), 32'd0);

        // busy stuck: timeout, with a REARM landing on the timeout edge
        CH_EN = 4'b1100; busy_mode = 3; REARM = 1'b1;
        run_seq(400, -1, 270, edges, fr_or, fr_cnt, err_cnt);
        check("d_done_edge", edges, 271);
        check("d_timeout", 32'(TIMEOUT), 32'd1);
        tick(); tick();
        check("d_rearm_dropped", 32'(DONE), 32'd1);

        // replica upset mid Reset_FIFOs
        CH_EN = 4'b1111; busy_mode = 0; REARM = 1'b1;
        run_seq(400, 10, -1, edges, fr_or, fr_cnt, err_cnt);
        check("e_done_edge", edges, 31);
        check("e_tmr_err_cycles", err_cnt, 1);
        check("e_fifo_cycles", fr_cnt, 10);
        check("e_timeout_cleared", 32'(TIMEOUT), 32'd0);

        // randomised re-arms, first one with every channel masked
        busy_mode = 1;
        for (int i = 0; i < 6; i++) begin
            CH_EN = (i == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            REARM = 1'b1;
            run_seq(400, -1, $urandom_range(2, 40), edges, fr_or, fr_cnt, err_cnt);
            if (i == 0) check("f_masked_fifo_or", 32'(fr_or), 32'h0);
        end

        // async reset in the middle of Pause
        busy_mode = 0; CH_EN = 4'b1111; REARM = 1'b1;
        repeat (20) tick();
        #2 RST_B = 1'b0;
        #1;
        check("g_async_fifo", 32'(FIFO_RST), 32'h0f);
        check("g_async_done", 32'(DONE), 32'd0);
        check("g_async_busy", 32'(BUSY), 32'd1);
        tick(); tick();
        RST_B = 1'b1;
        run_seq(400, -1, -1, edges, fr_or, fr_cnt, err_cnt);
        check("g_done_edge", edges, 31);

        tick();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
